// File: rtl/serial_transmitter_pkg.sv
// rtl/serial_transmitter_pkg.sv - shared serial line states and constants
// Purpose: FSM state type and line-level constants shared by the serial
//          transmitter and the matching receiver.
// Ports:   none (package)
package serial_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/serial_transmitter_bit_timer.sv
// rtl/serial_transmitter_bit_timer.sv - bit-period counter for the serial transmitter
// Purpose: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Ports:
//   clk   - clock, posedge
//   reset - synchronous active-high reset
//   clear - restart the period at count 0 on the next cycle
//   tick  - high in the last cycle of the current bit period
module bit_timer
    import serial_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_transmitter.sv
// rtl/serial_transmitter.sv - byte-to-serial transmit stage with holding register
// Purpose: frames bytes as start, 8 data bits LSB first, optional parity and
//          1 or 2 stop bits on an idle-high registered serial line.
// Ports:
//   clk        - clock, posedge
//   reset      - synchronous active-high reset
//   tx_data    - byte to send, sampled on handshake
//   tx_valid   - tx_data is valid
//   tx_ready   - holding register empty
//   out        - registered serial line
//   busy       - a frame is on the line
//   frame_done - pulse in the last cycle of the final stop bit
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       out,
    output logic       busy,
    output logic       frame_done
);

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       par, par_n;
    logic       out_n;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       take_hold;
    logic       tick;
    logic       timer_clear;

    // Restart the bit period whenever the state changes; IDLE keeps it parked
    // at zero so START always gets a full period.
    assign timer_clear = (state_n != state) || (state == IDLE);

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        par_n      = par;
        take_hold  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_n   = hold_data;
                    par_n     = (^hold_data) ^ (PARITY_ODD != 0);
                    take_hold = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                end
            end
            STOP: begin
                // bit_cnt counts stop-bit periods here
                if (tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        bit_cnt_n  = '0;
                        if (hold_full) begin
                            shift_n   = hold_data;
                            par_n     = (^hold_data) ^ (PARITY_ODD != 0);
                            take_hold = 1'b1;
                            state_n   = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line value is computed for the upcoming state so the flop shows it
        // in the same cycle the FSM enters that state.
        case (state_n)
            START:   out_n = START_BIT;
            DATA:    out_n = shift_n[0];
            PARITY:  out_n = par_n;
            default: out_n = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            out       <= LINE_IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            out     <= out_n;
            // A new byte wins over the shifter emptying the register.
            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE);

endmodule
